// File: rtl/areg_booth_if.sv
// Booth A-register bus: controller-side op select and operands, register-side results.
//   master: drives ctrl/in/m, observes o/shiftBit/ovf/cnt/done (Booth controller)
//   slave : the A register itself
interface areg_booth_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEPS = WIDTH,
  parameter int unsigned CW    = $clog2(STEPS + 1)
);
  logic [2:0]       ctrl;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] o;
  logic             shiftBit;
  logic             ovf;
  logic [CW-1:0]    cnt;
  logic             done;

  modport master (output ctrl, in, m, input o, shiftBit, ovf, cnt, done);
  modport slave  (input ctrl, in, m, output o, shiftBit, ovf, cnt, done);
endinterface

// File: rtl/areg_booth.sv
// Accumulator (A) register for a Booth multiplier: load/clear/hold, arithmetic
// shift right, add/sub of the multiplicand, fused add/sub-then-shift, and a
// saturating step counter that flags a completed STEPS-long sequence.
//   clk, rst : clock and synchronous active-high reset
//   bus      : areg_booth_if.slave (ctrl, in, m -> o, shiftBit, ovf, cnt, done)
module areg_booth #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEPS = WIDTH,
  parameter int unsigned CW    = $clog2(STEPS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  areg_booth_if.slave   bus
);

  localparam int unsigned W = WIDTH;

  typedef enum logic [2:0] {
    OP_LOAD     = 3'b000,
    OP_CLEAR    = 3'b001,
    OP_ASHR     = 3'b010,
    OP_HOLD     = 3'b011,
    OP_ADD      = 3'b100,
    OP_SUB      = 3'b101,
    OP_ADD_ASHR = 3'b110,
    OP_SUB_ASHR = 3'b111
  } op_e;

  logic [W-1:0]  o_q, o_d;
  logic          shift_bit_q, shift_bit_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_w;
  logic [W:0]    ext_o, ext_m, s;

  // Sign-extended W+1 bit sum/difference: exact, so overflow and fused shifts
  // both derive from it.
  assign ext_o  = {o_q[W-1], o_q};
  assign ext_m  = {bus.m[W-1], bus.m};
  assign s      = bus.ctrl[0] ? (ext_o - ext_m) : (ext_o + ext_m);
  assign done_w = (cnt_q == CW'(STEPS));

  // Next-state selection; shift-type ops freeze once the sequence is done.
  always_comb begin
    o_d         = o_q;
    shift_bit_d = shift_bit_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    unique case (op_e'(bus.ctrl))
      OP_LOAD: begin
        o_d         = bus.in;
        shift_bit_d = 1'b0;
        ovf_d       = 1'b0;
        cnt_d       = '0;
      end
      OP_CLEAR: begin
        o_d         = '0;
        shift_bit_d = 1'b0;
        ovf_d       = 1'b0;
        cnt_d       = '0;
      end
      OP_ASHR: begin
        if (!done_w) begin
          o_d         = {o_q[W-1], o_q[W-1:1]};
          shift_bit_d = o_q[0];
          cnt_d       = cnt_q + CW'(1);
        end
      end
      OP_HOLD: begin
      end
      OP_ADD, OP_SUB: begin
        o_d   = s[W-1:0];
        // Truncation to W bits loses information iff the top two bits differ.
        ovf_d = s[W] ^ s[W-1];
      end
      OP_ADD_ASHR, OP_SUB_ASHR: begin
        if (!done_w) begin
          o_d         = s[W:1];
          shift_bit_d = s[0];
          ovf_d       = 1'b0;
          cnt_d       = cnt_q + CW'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q         <= '0;
      shift_bit_q <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      o_q         <= o_d;
      shift_bit_q <= shift_bit_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.o        = o_q;
  assign bus.shiftBit = shift_bit_q;
  assign bus.ovf      = ovf_q;
  assign bus.cnt      = cnt_q;
  assign bus.done     = done_w;

endmodule

// File: tb/tb_areg_booth.sv
module tb_areg_booth;

  localparam logic [2:0] LOAD = 3'b000, CLEAR = 3'b001, ASHR = 3'b010, HOLD = 3'b011;
  localparam logic [2:0] ADD = 3'b100, SUB = 3'b101, ADD_ASHR = 3'b110, SUB_ASHR = 3'b111;

  logic clk = 1'b0;
  logic rst4, rst8;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  areg_booth_if #(.WIDTH(4)) b4 ();
  areg_booth_if #(.WIDTH(8)) b8 ();

  areg_booth #(.WIDTH(4)) u4 (.clk(clk), .rst(rst4), .bus(b4.slave));
  areg_booth #(.WIDTH(8)) u8 (.clk(clk), .rst(rst8), .bus(b8.slave));

  // Reference state: o as unsigned integer, plus flags and step count.
  int mo4, msb4, movf4, mcnt4;
  int mo8, msb8, movf8, mcnt8;

  function automatic int sval(input int x, input int w);
    return (x >= (1 << (w - 1))) ? x - (1 << w) : x;
  endfunction

  // Behavioural model: signed integer arithmetic, floor-halving for shifts.
  task automatic model_step(input int w, input int steps, input bit r, input logic [2:0] c,
                            input int inv, input int mv,
                            inout int mo, inout int msb, inout int movf, inout int mcnt);
    int t;
    int mask;
    mask = (1 << w) - 1;
    if (r || c == CLEAR) begin
      mo = 0; msb = 0; movf = 0; mcnt = 0;
    end else if (c == LOAD) begin
      mo = inv & mask; msb = 0; movf = 0; mcnt = 0;
    end else if (c == ADD || c == SUB) begin
      t    = (c == ADD) ? sval(mo, w) + sval(mv, w) : sval(mo, w) - sval(mv, w);
      movf = (t > (1 << (w - 1)) - 1 || t < -(1 << (w - 1))) ? 1 : 0;
      mo   = t & mask;
    end else if (c != HOLD && mcnt != steps) begin
      if (c == ASHR)          t = sval(mo, w);
      else if (c == ADD_ASHR) t = sval(mo, w) + sval(mv, w);
      else                    t = sval(mo, w) - sval(mv, w);
      if (c != ASHR) movf = 0;
      msb  = t & 1;
      mo   = (t >>> 1) & mask;
      mcnt = mcnt + 1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op4(input bit r, input logic [2:0] c, input int inv, input int mv);
    @(negedge clk);
    rst4 = r; b4.ctrl = c; b4.in = 4'(inv); b4.m = 4'(mv);
    model_step(4, 4, r, c, inv, mv, mo4, msb4, movf4, mcnt4);
    @(posedge clk); #1;
    chk("w4.o",    int'(b4.o),        mo4);
    chk("w4.sb",   int'(b4.shiftBit), msb4);
    chk("w4.ovf",  int'(b4.ovf),      movf4);
    chk("w4.cnt",  int'(b4.cnt),      mcnt4);
    chk("w4.done", int'(b4.done),     (mcnt4 == 4) ? 1 : 0);
    rst4 = 1'b0;
  endtask

  task automatic op8(input bit r, input logic [2:0] c, input int inv, input int mv);
    @(negedge clk);
    rst8 = r; b8.ctrl = c; b8.in = 8'(inv); b8.m = 8'(mv);
    model_step(8, 8, r, c, inv, mv, mo8, msb8, movf8, mcnt8);
    @(posedge clk); #1;
    chk("w8.o",    int'(b8.o),        mo8);
    chk("w8.sb",   int'(b8.shiftBit), msb8);
    chk("w8.ovf",  int'(b8.ovf),      movf8);
    chk("w8.cnt",  int'(b8.cnt),      mcnt8);
    chk("w8.done", int'(b8.done),     (mcnt8 == 8) ? 1 : 0);
    rst8 = 1'b0;
  endtask

  initial begin
    logic [2:0] c;
    int         mv;
    rst4 = 1'b1; rst8 = 1'b1;
    b4.ctrl = HOLD; b4.in = '0; b4.m = '0;
    b8.ctrl = HOLD; b8.in = '0; b8.m = '0;

    // Reset and legacy ops, WIDTH=4
    op4(1, HOLD, 0, 0);
    chk("rst_o", int'(b4.o), 0);
    op4(0, LOAD, 4'b0111, 0);  chk("load_o", int'(b4.o), 7);
    op4(0, HOLD, 0, 0);        chk("hold_o", int'(b4.o), 7);
    op4(0, ASHR, 0, 0);        chk("ashr_o", int'(b4.o), 3);  chk("ashr_sb", int'(b4.shiftBit), 1);
    op4(0, LOAD, 4'b1010, 0);
    op4(0, ASHR, 0, 0);        chk("ashr_neg_o", int'(b4.o), 4'hd); chk("ashr_neg_sb", int'(b4.shiftBit), 0);

    // Overflow
    op4(0, LOAD, 4'b0111, 0);
    op4(0, ADD, 0, 1);         chk("add_ovf_o", int'(b4.o), 8); chk("add_ovf", int'(b4.ovf), 1);
    op4(0, SUB, 0, 1);         chk("sub_ovf_o", int'(b4.o), 7); chk("sub_ovf", int'(b4.ovf), 1);
    op4(0, LOAD, 4'b0010, 0);
    op4(0, ADD, 0, 1);         chk("add_ok_o", int'(b4.o), 3);  chk("add_ok_ovf", int'(b4.ovf), 0);

    // Fused ops
    op4(0, LOAD, 0, 0);
    op4(0, SUB_ASHR, 0, 3);    chk("subashr_o", int'(b4.o), 4'he); chk("subashr_sb", int'(b4.shiftBit), 1);
    op4(0, LOAD, 4'b0111, 0);
    op4(0, ADD_ASHR, 0, 7);    chk("addashr_o", int'(b4.o), 7); chk("addashr_sb", int'(b4.shiftBit), 0);

    // Counter and saturation
    op4(0, LOAD, 4'b0110, 0);
    for (int i = 0; i < 4; i++) op4(0, ASHR, 0, 0);
    chk("sat_cnt", int'(b4.cnt), 4); chk("sat_done", int'(b4.done), 1);
    op4(0, ASHR, 0, 0);        chk("sat_hold_cnt", int'(b4.cnt), 4);
    op4(0, SUB_ASHR, 0, 5);
    op4(0, ADD, 0, 2);
    op4(0, LOAD, 4'b0001, 0);  chk("reload_cnt", int'(b4.cnt), 0); chk("reload_done", int'(b4.done), 0);

    // Reset mid-sequence dominates ctrl
    op4(0, ASHR, 0, 0);
    op4(0, ASHR, 0, 0);
    op4(1, ADD_ASHR, 0, 3);    chk("midrst_cnt", int'(b4.cnt), 0);
    op4(0, ASHR, 0, 0);        chk("postrst_cnt", int'(b4.cnt), 1);

    // Randomized ops, WIDTH=4 (SUB with the most-negative m left out)
    for (int i = 0; i < 400; i++) begin
      c  = 3'($urandom_range(0, 7));
      mv = int'($urandom_range(0, 15));
      if (c == SUB && mv == 8) mv = 7;
      if ($urandom_range(0, 9) == 0) c = LOAD;
      op4($urandom_range(0, 60) == 0, c, int'($urandom_range(0, 15)), mv);
    end

    // WIDTH=8
    op8(1, HOLD, 0, 0);
    op8(0, LOAD, 8'h81, 0);
    op8(0, ASHR, 0, 0);        chk("w8_ashr_o", int'(b8.o), 8'hc0); chk("w8_ashr_sb", int'(b8.shiftBit), 1);
    op8(0, LOAD, int'($urandom_range(0, 255)), 0);
    for (int i = 0; i < 7; i++) op8(0, ($urandom_range(0, 1) == 1) ? ADD_ASHR : SUB_ASHR, 0,
                                    int'($urandom_range(0, 127)));
    chk("w8_done_early", int'(b8.done), 0);
    op8(0, ASHR, 0, 0);
    chk("w8_done_at8", int'(b8.done), 1);
    for (int i = 0; i < 300; i++) begin
      c  = 3'($urandom_range(0, 7));
      mv = int'($urandom_range(0, 255));
      if (c == SUB && mv == 8'h80) mv = 8'h7f;
      if ($urandom_range(0, 11) == 0) c = LOAD;
      op8($urandom_range(0, 60) == 0, c, int'($urandom_range(0, 255)), mv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/areg_booth.md
# areg_booth

Parametrised accumulator (A) register for the Booth multiplier datapath. It supersedes the fixed 4-bit load/reset/shift/hold A register with the following additions:
- configurable width;
- in-register add/subtract of the multiplicand;
- fused add-then-arithmetic-shift operations;
- a step counter that flags completion of a WIDTH-step Booth sequence.

It sits between the Booth controller, which drives `ctrl`, and the Q register, which consumes `shiftBit` as its serial input.

## Interface

- `WIDTH`, default 4: data width of A, M and load input; minimum 2.
- `STEPS`, default WIDTH: number of shift-type operations that completes a sequence.
- `CW`, default $clog2(STEPS+1): counter width (derived; do not override).

- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset; dominates `ctrl`.
- `ctrl` input 3: operation select (encoding below).
- `in` input WIDTH: parallel load data.
- `m` input WIDTH: multiplicand, two's complement.
- `o` output WIDTH: A register contents.
- `shiftBit` output 1: registered bit shifted out of A's LSB on the last shift-type op.
- `ovf` output 1: signed overflow of the last standalone ADD/SUB.
- `cnt` output CW: shift-type ops performed since last LOAD/CLEAR/reset.
- `done` output 1: high when `cnt == STEPS`.

## Operation

- Encoding: `ctrl[2]=0` keeps the legacy codes.
  - 000 LOAD
  - 001 CLEAR
  - 010 ASHR
  - 011 HOLD
  - 100 ADD
  - 101 SUB
  - 110 ADD_ASHR
  - 111 SUB_ASHR
- Reset or CLEAR: `o`=0, `shiftBit`=0, `ovf`=0, `cnt`=0, `done`=0.
- LOAD: `o`<=`in`; `shiftBit`<=0; `ovf`<=0; `cnt`<=0.
- HOLD: all state retained.
- ASHR: `o`<={o[W-1], o[W-1:1]}; `shiftBit`<=o[0]; `cnt`+1; `ovf` retained.
- ADD / SUB:
  - `o`<=(o ± m) mod 2^W.
  - `ovf`<=1 iff the operands' sign bits match (for SUB, compare o against the sign of -m) and the result's sign differs.
  - `shiftBit` and `cnt` retained.
- ADD_ASHR / SUB_ASHR:
  - Form s = sext(o) ± sext(m) at WIDTH+1 bits; this is exact and cannot overflow.
  - `o`<=s[W:1]; `shiftBit`<=s[0]; `ovf`<=0; `cnt`+1.
- Saturation: while `done`=1, ASHR, ADD_ASHR and SUB_ASHR act as HOLD, so `o`, `shiftBit` and `cnt` are unchanged. ADD, SUB, LOAD and CLEAR still operate.
- `cnt` never wraps; the maximum is STEPS.
- `done` is combinational from registered `cnt` (`cnt==STEPS`); it carries no extra state.
- Sequence states are implicit in `cnt`:
  - IDLE/READY: cnt=0.
  - RUNNING: 0<cnt<STEPS.
  - DONE: cnt=STEPS.
  - Transitions occur only on shift-type ops (advance) or LOAD/CLEAR/rst (return to 0).

## Timing

- Every op takes effect on the rising edge at which it is sampled. Results are visible on `o`, `shiftBit`, `ovf` and `cnt` after that edge, so latency is 1 cycle with no multi-cycle ops.
- `in`, `m` and `ctrl` are sampled only at the rising edge; there is no handshake. The controller issues one op per cycle.
- `rst`=1 at an edge forces reset values regardless of `ctrl`, including mid-sequence. `done` drops the same cycle as `cnt`.
- A LOAD issued while `done`=1 restarts the sequence: the next shift-type op gives `cnt`=1.
- With STEPS=WIDTH, a full Booth run is LOAD followed by WIDTH fused/ASHR ops. `done` is high in the cycle after the final op.

## Test plan

- Reset/legacy (WIDTH=4):
  - rst=1 -> `o`=0000, `shiftBit`=0, `cnt`=0.
  - LOAD `in`=0111 -> `o`=0111.
  - HOLD -> `o`=0111.
  - ASHR -> `o`=0011, `shiftBit`=1.
  - LOAD 1010, then ASHR -> `o`=1101, `shiftBit`=0.
- Overflow:
  - LOAD 0111, `m`=0001, ADD -> `o`=1000, `ovf`=1.
  - Then SUB `m`=0001 -> `o`=0111, `ovf`=1.
  - LOAD 0010, ADD `m`=0001 -> `o`=0011, `ovf`=0.
- Fused ops:
  - LOAD 0000, `m`=0011, SUB_ASHR -> `o`=1110, `shiftBit`=1, `ovf`=0.
  - LOAD 0111, `m`=0111, ADD_ASHR -> `o`=0111, `shiftBit`=0. This is exact: no overflow loss.
- Counter/saturation:
  - LOAD, then 4×ASHR -> `cnt`=4, `done`=1.
  - A 5th ASHR -> `o`, `shiftBit` and `cnt` unchanged.
  - ADD still updates `o`.
  - LOAD -> `cnt`=0, `done`=0.
- Reset mid-operation:
  - After 2 shifts, assert rst with `ctrl`=ADD_ASHR -> all outputs at reset values next cycle.
  - Deassert, then ASHR -> `cnt`=1.
- Parametric: WIDTH=8, STEPS=8.
  - LOAD 8'h81, ASHR -> `o`=8'hC0, `shiftBit`=1.
  - `done` asserts after exactly 8 shift-type ops.
